// File: rtl/frame_pkg.sv
// Shared definitions for the preamble frame link.
// Holds the FSM state encoding, the default preamble and a counter-width helper.
package frame_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      DATA = 3'd2,
      GAP  = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam logic [3:0] DEFAULT_PREAMBLE = 4'b1010;

   // Wide enough for the longest phase, with headroom so a reload never truncates.
   function automatic int cnt_width(input int pre_w, input int data_w, input int gap_cycles);
      int m;
      m = 2;
      if (pre_w > m)      m = pre_w;
      if (data_w > m)     m = data_w;
      if (gap_cycles > m) m = gap_cycles;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register, MSB out first.
// Load has priority over shift; zeros are shifted in from the LSB side.
module piso_shreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         sout
);

   logic [W-1:0] sreg_reg;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sreg_reg <= '0;
      end else if (load) begin
         sreg_reg <= din;
      end else if (shift) begin
         sreg_reg <= sreg_reg << 1;
      end
   end

   assign sout = sreg_reg[W-1];

endmodule

// File: rtl/preamble_frame_tx.sv
// Serial frame transmitter: preamble, payload MSB-first, then idle-zero gap.
// Moore FSM; out/busy/done decode only from registered state and shift registers.
module preamble_frame_tx
   import frame_pkg::*;
#(
   parameter int               DATA_W     = 8,
   parameter int               PRE_W      = 4,
   parameter logic [PRE_W-1:0] PREAMBLE   = PRE_W'(DEFAULT_PREAMBLE),
   parameter int               GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic              out,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = cnt_width(PRE_W, DATA_W, GAP_CYCLES);

   localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_W);
   localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             accept;
   logic             pre_shift, data_shift;
   logic             pre_bit, data_bit;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = IDLE;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      pre_shift  = 1'b0;
      data_shift = 1'b0;
      out        = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = PRE;
               cnt_next   = PRE_LOAD;
            end else begin
               state_next = IDLE;
            end
         end

         PRE: begin
            out       = pre_bit;
            busy      = 1'b1;
            pre_shift = 1'b1;
            if (cnt_reg == CNT_LAST) begin
               state_next = DATA;
               cnt_next   = DATA_LOAD;
            end else begin
               state_next = PRE;
               cnt_next   = cnt_reg - CNT_LAST;
            end
         end

         DATA: begin
            out        = data_bit;
            busy       = 1'b1;
            data_shift = 1'b1;
            if (cnt_reg == CNT_LAST) begin
               // A zero-length gap skips straight to the completion pulse.
               if (GAP_CYCLES > 0) begin
                  state_next = GAP;
                  cnt_next   = GAP_LOAD;
               end else begin
                  state_next = DONE;
                  cnt_next   = '0;
               end
            end else begin
               state_next = DATA;
               cnt_next   = cnt_reg - CNT_LAST;
            end
         end

         GAP: begin
            busy = 1'b1;
            if (cnt_reg == CNT_LAST) begin
               state_next = DONE;
               cnt_next   = '0;
            end else begin
               state_next = GAP;
               cnt_next   = cnt_reg - CNT_LAST;
            end
         end

         DONE: begin
            done = 1'b1;
            if (start) begin
               accept     = 1'b1;
               state_next = PRE;
               cnt_next   = PRE_LOAD;
            end else begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end

         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   piso_shreg #(.W(PRE_W)) u_pre_shreg (
      .clk   (clk),
      .clr   (clr),
      .load  (accept),
      .shift (pre_shift),
      .din   (PREAMBLE),
      .sout  (pre_bit)
   );

   piso_shreg #(.W(DATA_W)) u_data_shreg (
      .clk   (clk),
      .clr   (clr),
      .load  (accept),
      .shift (data_shift),
      .din   (data_in),
      .sout  (data_bit)
   );

endmodule

// File: tb/tb_preamble_frame_tx.sv
// Scoreboard bench for preamble_frame_tx: stimulus pushes expected line cycles, monitor compares.
// A second instance checks the GAP_CYCLES=0, DATA_W=4 variant with a directed frame.
module tb_preamble_frame_tx;
   import frame_pkg::*;

   localparam int             DW  = 8;
   localparam int             PW  = 4;
   localparam int             GC  = 2;
   localparam logic [PW-1:0]  PRE = 4'b1010;

   typedef struct packed {
      logic o;
      logic b;
      logic d;
   } exp_t;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          out, busy, done;

   logic          clr2 = 1'b1;
   logic          start2 = 1'b0;
   logic [3:0]    data_in2 = '0;
   logic          out2, busy2, done2;

   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;
   bit   var_done = 1'b0;
   exp_t sb[$];
   exp_t pending[$];
   exp_t last = '0;

   always #5 clk = ~clk;

   preamble_frame_tx #(.DATA_W(DW), .PRE_W(PW), .PREAMBLE(PRE), .GAP_CYCLES(GC)) dut (
      .clk(clk), .clr(clr), .start(start), .data_in(data_in),
      .out(out), .busy(busy), .done(done)
   );

   preamble_frame_tx #(.DATA_W(4), .PRE_W(PW), .PREAMBLE(PRE), .GAP_CYCLES(0)) dut2 (
      .clk(clk), .clr(clr2), .start(start2), .data_in(data_in2),
      .out(out2), .busy(busy2), .done(done2)
   );

   // Monitor: one expected entry per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_underflow t=%0t: no expected entry for this cycle", $time);
         end else begin
            e = sb.pop_front();
            if ({out, busy, done} !== e) begin
               fails++;
               $display("FAIL line t=%0t out/busy/done got %b%b%b want %b%b%b",
                        $time, out, busy, done, e.o, e.b, e.d);
            end
         end
      end
   end

   // Reference frame: what the line shows on each cycle after an accepting edge.
   task automatic push_frame(input logic [DW-1:0] d);
      exp_t          t;
      logic [PW-1:0] pv;
      pv = PRE;
      for (int i = PW - 1; i >= 0; i--) begin
         t = {pv[i], 1'b1, 1'b0};
         pending.push_back(t);
      end
      for (int i = DW - 1; i >= 0; i--) begin
         t = {d[i], 1'b1, 1'b0};
         pending.push_back(t);
      end
      for (int i = 0; i < GC; i++) begin
         t = 3'b010;
         pending.push_back(t);
      end
      t = 3'b001;
      pending.push_back(t);
   endtask

   // Called 1 time unit after a rising edge; drives inputs for the next edge.
   task automatic step(input bit s, input logic [DW-1:0] d);
      start   = s;
      data_in = d;
      if (s && !last.b && !last.d && pending.size() == 0) push_frame(d);
      else if (s && last.d) push_frame(d);
      if (pending.size() > 0) last = pending.pop_front();
      else last = '0;
      sb.push_back(last);
      @(posedge clk);
      #1;
   endtask

   task automatic check_now(input string name, input logic [2:0] got, input logic [2:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s t=%0t got %b want %b", name, $time, got, want);
      end
   endtask

   // Asynchronous clear between edges, then resynchronise the scoreboard to IDLE.
   task automatic async_clear(input bit expect_busy);
      mon_en = 1'b0;
      if (expect_busy) check_now("busy_before_clr", {2'b00, busy}, 3'b001);
      start = 1'b0;
      #2;
      clr = 1'b1;
      #1;
      check_now("async_clr_outputs", {out, busy, done}, 3'b000);
      @(posedge clk);
      #1;
      check_now("clr_held_outputs", {out, busy, done}, 3'b000);
      clr = 1'b0;
      sb.delete();
      pending.delete();
      last = '0;
      sb.push_back(last);
      mon_en = 1'b1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      check_now("reset_outputs", {out, busy, done}, 3'b000);
      async_clear(1'b0);

      // Idle after reset.
      for (int i = 0; i < 20; i++) step(1'b0, DW'($urandom));

      // Single frame C5; mid-DATA, data_in moves to 3C and start pulses.
      step(1'b1, 8'hC5);
      for (int i = 0; i < 16; i++)
         step(i == 7, (i >= 5) ? 8'h3C : DW'($urandom));

      // Back-to-back frames under continuous start.
      for (int i = 0; i < 15; i++) step(1'b1, 8'hFF);
      for (int i = 0; i < 15; i++) step(1'b1, 8'h00);
      for (int i = 0; i < 5; i++)  step(1'b0, 8'h00);

      // Abort during DATA, then a full frame after release.
      step(1'b1, 8'h96);
      for (int i = 0; i < 6; i++) step(1'b0, DW'($urandom));
      async_clear(1'b1);
      step(1'b1, 8'h5A);
      for (int i = 0; i < 18; i++) step(1'b0, DW'($urandom));

      // Randomised traffic with occasional aborts.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) async_clear(last.b);
         step($urandom_range(0, 3) == 0, DW'($urandom));
      end
      for (int i = 0; i < 20; i++) step(1'b0, DW'($urandom));

      @(negedge clk);
      #1;
      mon_en = 1'b0;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_drain got %0d entries left want 0", sb.size());
      end

      for (int i = 0; i < 100 && !var_done; i++) @(posedge clk);
      if (!var_done) begin
         tests++;
         fails++;
         $display("FAIL variant_timeout got unfinished want finished");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Variant: DATA_W=4, GAP_CYCLES=0, payload A -> 1010 1010 then DONE.
   initial begin
      logic [7:0] v;
      logic [2:0] w;
      v = {PRE, 4'hA};
      repeat (3) @(posedge clk);
      #1;
      clr2 = 1'b0;
      @(posedge clk);
      #1;
      start2   = 1'b1;
      data_in2 = 4'hA;
      @(posedge clk);
      #1;
      start2   = 1'b0;
      data_in2 = 4'h5;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k < 8)       w = {v[7-k], 1'b1, 1'b0};
         else if (k == 8) w = 3'b001;
         else             w = 3'b000;
         tests++;
         if ({out2, busy2, done2} !== w) begin
            fails++;
            $display("FAIL variant_cycle%0d out/busy/done got %b%b%b want %b",
                     k, out2, busy2, done2, w);
         end
      end
      var_done = 1'b1;
   end

endmodule
